ieeedrv_sd_arbiter: RTL and testbench

// Downstream of the IEEE drive complex: merges the per-block-device SD requests (lba/blk_cnt/rd/wr/buff_din,
// one set per drive subunit) onto a single host block-device port. Round-robin grant, one transfer in flight.

---
 rtl/ieeedrv_sd_arbiter_if.sv | 20 ++
 rtl/ieeedrv_sd_arbiter.sv | 157 +++++++++++++++
 tb/tb_ieeedrv_sd_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ieeedrv_sd_arbiter_if.sv
// Host-side block-device port shared by the SD arbiter and the host.
// The arbiter drives the request and write data; the host returns the ack.
interface ieeedrv_sd_arbiter_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    output sd_ack
  );
endinterface

// File: rtl/ieeedrv_sd_arbiter.sv
// Round-robin arbiter merging per-drive SD block requests onto one host port,
// one transfer in flight, with a request watchdog against a dead host.
//
// state   | meaning
// IDLE    | searching from grant+1 for the next requester
// REQ     | sd_rd/sd_wr raised, waiting for host ack, watchdog running
// XFER    | host transferring, ack routed to the granted device
// REL     | one cycle with ack forced low before re-arbitration
module ieeedrv_sd_arbiter #(
  parameter int NBD  = 2,
  parameter int TO_W = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NBD-1:0][31:0]  dev_lba,
  input  logic [NBD-1:0][5:0]   dev_blk_cnt,
  input  logic [NBD-1:0]        dev_rd,
  input  logic [NBD-1:0]        dev_wr,
  input  logic [NBD-1:0][7:0]   dev_buff_din,
  output logic [NBD-1:0]        dev_ack,
  ieeedrv_sd_arbiter_if.master  sd,
  output logic [2:0]            grant,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_REL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_grant;
  logic [31:0]       r_lba;
  logic [5:0]        r_blk_cnt;
  logic              r_sd_rd;
  logic              r_sd_wr;
  logic [TO_W-1:0]   r_wdog;

  logic              w_found;
  logic [2:0]        w_pick;
  logic [2:0]        w_idx;
  logic              w_timeout;
  logic              w_ack_en;
  logic [7:0]        w_ack8;
  logic [7:0]        w_rd8;
  logic [7:0]        w_wr8;
  logic [7:0]        w_req8;
  logic [7:0][31:0]  w_lba8;
  logic [7:0][5:0]   w_cnt8;
  logic [7:0][7:0]   w_din8;

  // Pad device vectors to 8 entries so a 3-bit grant indexes them for any NBD.
  always_comb begin
    w_rd8  = '0;
    w_wr8  = '0;
    w_lba8 = '0;
    w_cnt8 = '0;
    w_din8 = '0;
    for (int i = 0; i < NBD; i++) begin
      w_rd8[i]  = dev_rd[i];
      w_wr8[i]  = dev_wr[i];
      w_lba8[i] = dev_lba[i];
      w_cnt8[i] = dev_blk_cnt[i];
      w_din8[i] = dev_buff_din[i];
    end
    w_req8 = w_rd8 | w_wr8;
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_grant;
    w_idx   = '0;
    for (int k = 1; k <= NBD; k++) begin
      w_idx = 3'((int'(r_grant) + k) % NBD);
      if (!w_found && w_req8[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_ack_en    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_REQ;
      ST_REQ: begin
        w_ack_en = 1'b1;
        if (sd.sd_ack) begin
          w_state_nxt = ST_XFER;
        end else if (&r_wdog) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        w_ack_en = 1'b1;
        if (!sd.sd_ack) w_state_nxt = ST_REL;
      end
      ST_REL:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read beats write when a device raises both; the write stays pending.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_grant   <= 3'(NBD - 1);
      r_lba     <= '0;
      r_blk_cnt <= '0;
      r_sd_rd   <= 1'b0;
      r_sd_wr   <= 1'b0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_found) begin
          r_grant   <= w_pick;
          r_lba     <= w_lba8[w_pick];
          r_blk_cnt <= w_cnt8[w_pick];
          r_sd_rd   <= w_rd8[w_pick];
          r_sd_wr   <= !w_rd8[w_pick];
          r_wdog    <= '0;
        end
        ST_REQ: begin
          if (sd.sd_ack || (&r_wdog)) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ack8          = '0;
    w_ack8[r_grant] = sd.sd_ack & w_ack_en;
  end

  assign dev_ack        = w_ack8[NBD-1:0];
  assign sd.sd_lba      = r_lba;
  assign sd.sd_blk_cnt  = r_blk_cnt;
  assign sd.sd_rd       = r_sd_rd;
  assign sd.sd_wr       = r_sd_wr;
  assign sd.sd_buff_din = w_din8[r_grant];
  assign grant          = r_grant;
  assign busy           = (r_state != ST_IDLE);
  assign timeout        = w_timeout;

endmodule

// File: tb/tb_ieeedrv_sd_arbiter.sv
// Directed bench for the SD arbiter: NBD=2, short watchdog (TO_W=4) so the
// timeout path is reachable quickly.
module tb_ieeedrv_sd_arbiter;
  logic             clk_sys = 1'b0;
  logic             reset;
  logic [1:0][31:0] dev_lba;
  logic [1:0][5:0]  dev_blk_cnt;
  logic [1:0]       dev_rd;
  logic [1:0]       dev_wr;
  logic [1:0][7:0]  dev_buff_din;
  logic [1:0]       dev_ack;
  logic [2:0]       grant;
  logic             busy;
  logic             timeout;
  int               n_checks = 0;
  int               n_errors = 0;

  ieeedrv_sd_arbiter_if sd_if ();

  ieeedrv_sd_arbiter #(.NBD(2), .TO_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .dev_lba      (dev_lba),
    .dev_blk_cnt  (dev_blk_cnt),
    .dev_rd       (dev_rd),
    .dev_wr       (dev_wr),
    .dev_buff_din (dev_buff_din),
    .dev_ack      (dev_ack),
    .sd           (sd_if),
    .grant        (grant),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Entered in the first REQ cycle of a grant; leaves in the following IDLE cycle.
  task automatic serve(input int dev, input bit wr, input logic [31:0] exp_lba,
                       input logic [5:0] exp_cnt, input logic [7:0] exp_din, input int ncyc);
    chk("sd_rd",      32'(sd_if.sd_rd), 32'(!wr));
    chk("sd_wr",      32'(sd_if.sd_wr), 32'(wr));
    chk("sd_lba",     sd_if.sd_lba, exp_lba);
    chk("sd_blk_cnt", 32'(sd_if.sd_blk_cnt), 32'(exp_cnt));
    chk("grant",      32'(grant), 32'(dev));
    chk("busy_req",   32'(busy), 32'd1);
    chk("buff_din",   32'(sd_if.sd_buff_din), 32'(exp_din));
    sd_if.sd_ack = 1'b1;
    if (wr) dev_wr[dev] = 1'b0;
    else    dev_rd[dev] = 1'b0;
    #1;
    chk("dev_ack_on", 32'(dev_ack), 32'(1 << dev));
    for (int i = 1; i < ncyc; i++) begin
      tick();
      chk("dev_ack_on", 32'(dev_ack), 32'(1 << dev));
    end
    tick();
    sd_if.sd_ack = 1'b0;
    #1;
    chk("dev_ack_off", 32'(dev_ack), 32'd0);
    chk("busy_xfer",   32'(busy), 32'd1);
    chk("rdwr_clr",    32'({sd_if.sd_rd, sd_if.sd_wr}), 32'd0);
    tick();
    chk("busy_rel",    32'(busy), 32'd1);
    tick();
    chk("busy_idle",   32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int to_cyc;
    reset        = 1'b1;
    dev_lba      = '0;
    dev_blk_cnt  = '0;
    dev_rd       = '0;
    dev_wr       = '0;
    dev_buff_din = '0;
    sd_if.sd_ack = 1'b0;
    tick();
    tick();
    chk("rst_sd_rd",   32'(sd_if.sd_rd), 32'd0);
    chk("rst_sd_wr",   32'(sd_if.sd_wr), 32'd0);
    chk("rst_sd_lba",  sd_if.sd_lba, 32'd0);
    chk("rst_blk_cnt", 32'(sd_if.sd_blk_cnt), 32'd0);
    chk("rst_dev_ack", 32'(dev_ack), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_grant",   32'(grant), 32'd1);
    reset = 1'b0;

    // Single read from device 0, host acks 4 cycles after 2 cycles of waiting.
    dev_lba[0]     = 32'h123;
    dev_blk_cnt[0] = 6'd3;
    dev_lba[1]     = 32'h777;
    dev_rd         = 2'b01;
    #1;
    chk("idle_sd_rd", 32'(sd_if.sd_rd), 32'd0);
    tick();
    chk("req_dev_ack", 32'(dev_ack), 32'd0);
    tick();
    tick();
    serve(0, 1'b0, 32'h123, 6'd3, 8'h00, 4);

    // Contention after reset: device 0 read, device 1 write, twice round.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dev_lba[0]      = 32'h1000;
    dev_blk_cnt[0]  = 6'd1;
    dev_lba[1]      = 32'h2000;
    dev_blk_cnt[1]  = 6'd2;
    dev_buff_din[0] = 8'h5A;
    dev_buff_din[1] = 8'hA5;
    dev_rd[0] = 1'b1;
    dev_wr[1] = 1'b1;
    tick();
    serve(0, 1'b0, 32'h1000, 6'd1, 8'h5A, 2);
    tick();
    serve(1, 1'b1, 32'h2000, 6'd2, 8'hA5, 3);
    dev_rd[0] = 1'b1;
    dev_wr[1] = 1'b1;
    tick();
    serve(0, 1'b0, 32'h1000, 6'd1, 8'h5A, 1);
    tick();
    serve(1, 1'b1, 32'h2000, 6'd2, 8'hA5, 2);

    // Same device raises read and write: read first, then write, same lba.
    dev_lba[1]     = 32'hABCD0001;
    dev_blk_cnt[1] = 6'd7;
    dev_rd[1] = 1'b1;
    dev_wr[1] = 1'b1;
    tick();
    serve(1, 1'b0, 32'hABCD0001, 6'd7, 8'hA5, 2);
    tick();
    serve(1, 1'b1, 32'hABCD0001, 6'd7, 8'hA5, 2);

    // Spurious host ack in IDLE.
    sd_if.sd_ack = 1'b1;
    #1;
    chk("spur_dev_ack", 32'(dev_ack), 32'd0);
    tick();
    chk("spur_busy", 32'(busy), 32'd0);
    sd_if.sd_ack = 1'b0;

    // Watchdog: no ack, timeout in the 16th REQ cycle, then retry.
    dev_lba[0] = 32'h55;
    dev_rd[0]  = 1'b1;
    tick();
    to_cyc = 0;
    for (int c = 1; c <= 40 && to_cyc == 0; c++) begin
      if (timeout) to_cyc = c;
      else tick();
    end
    chk("to_cycle", 32'(to_cyc), 32'd16);
    chk("to_sd_rd_held", 32'(sd_if.sd_rd), 32'd1);
    tick();
    chk("to_sd_rd", 32'(sd_if.sd_rd), 32'd0);
    chk("to_busy",  32'(busy), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd0);
    chk("to_ack",   32'(dev_ack), 32'd0);
    tick();
    serve(0, 1'b0, 32'h55, 6'd1, 8'h5A, 1);

    // Reset during XFER; request drop in REQ is ignored beforehand.
    dev_rd[1] = 1'b1;
    tick();
    dev_rd[1] = 1'b0;
    tick();
    chk("drop_sd_rd", 32'(sd_if.sd_rd), 32'd1);
    chk("drop_busy",  32'(busy), 32'd1);
    sd_if.sd_ack = 1'b1;
    tick();
    chk("xfer_ack", 32'(dev_ack), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_sd_rd", 32'(sd_if.sd_rd), 32'd0);
    chk("mrst_sd_wr", 32'(sd_if.sd_wr), 32'd0);
    chk("mrst_ack",   32'(dev_ack), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd1);
    chk("mrst_busy",  32'(busy), 32'd0);
    tick();
    chk("mrst_spur_ack",  32'(dev_ack), 32'd0);
    chk("mrst_spur_busy", 32'(busy), 32'd0);
    sd_if.sd_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
